or_gate: RTL and testbench

// - 3-input logical OR (x1|x2|x3) with an optional N-bit extension vector.
// - Output q is purely combinational, so it is usable in clockless logic.
// - A registered, valid-qualified copy is also provided, for timing-closed datapaths.
// - Leaf glue cell used wherever control flags are merged (interrupt/error aggregation).

---
 rtl/or_gate_pkg.sv | 12 +
 rtl/or_pipe_stage.sv | 16 +
 rtl/or_gate.sv | 61 ++++++
 tb/tb_or_gate.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/or_gate_pkg.sv
// Shared types and limits for the or_gate leaf cell and its pipeline stages.
package or_gate_pkg;

   localparam int PIPE_STAGES_MAX = 4;
   localparam int CNT_W_DEFAULT   = 16;

   typedef struct packed {
      logic q;
      logic valid;
   } or_stage_t;

endpackage

// File: rtl/or_pipe_stage.sv
// One resettable {q, valid} register; latency 1 cycle, no backpressure.
module or_pipe_stage
   import or_gate_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  or_stage_t d,
   output or_stage_t r
);

   always_ff @(posedge clk) begin
      if (rst) r <= '0;
      else     r <= d;
   end

endmodule

// File: rtl/or_gate.sv
// Multi-input OR with combinational q plus a registered, valid-qualified copy,
// rising-edge pulse and saturating hit counter; no backpressure.
module or_gate
   import or_gate_pkg::*;
#(
   parameter int EXT_W       = 1,
   parameter int PIPE_STAGES = 1,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x1,
   input  logic             x2,
   input  logic             x3,
   input  logic [EXT_W-1:0] x_ext,
   input  logic             in_valid,
   output logic             q,
   output logic             q_r,
   output logic             q_r_valid,
   output logic             q_rise,
   output logic [CNT_W-1:0] hit_cnt
);

   or_stage_t stage [PIPE_STAGES+1];
   logic      prev_q;

   // No X masking: an unknown input reaches q exactly as the OR operator yields it.
   assign q        = x1 | x2 | x3 | (|x_ext);
   assign stage[0] = {q, in_valid};

   for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_pipe
      or_pipe_stage u_stage (
         .clk (clk),
         .rst (rst),
         .d   (stage[i]),
         .r   (stage[i+1])
      );
   end

   assign q_r       = stage[PIPE_STAGES].q;
   assign q_r_valid = stage[PIPE_STAGES].valid;

   // prev_q only tracks meaningful samples, so invalid gaps never fake an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
         q_rise <= 1'b0;
      end else begin
         q_rise <= q_r_valid & q_r & ~prev_q;
         if (q_r_valid) prev_q <= q_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         hit_cnt <= '0;
      else if (q_r_valid && q_r && (hit_cnt != '1))
         hit_cnt <= hit_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_or_gate.sv
// Directed bench for or_gate: truth table, x_ext, latency, edge/count, reset, saturation.
module tb_or_gate;

   localparam int EXT_W = 4;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst, x1, x2, x3, in_valid;
   logic [EXT_W-1:0] x_ext;
   logic        x_ext_s;
   logic        q, q_r, q_r_valid, q_rise;
   logic [15:0] hit_cnt;
   logic        q_s, q_r_s, q_r_valid_s, q_rise_s;
   logic [1:0]  hit_cnt_s;

   int tests = 0;
   int fails = 0;
   int rise_cnt;
   logic [2:0] code;
   int seq [5] = '{0, 1, 1, 0, 1};

   or_gate #(.EXT_W(EXT_W), .PIPE_STAGES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .x_ext(x_ext),
      .in_valid(in_valid), .q(q), .q_r(q_r), .q_r_valid(q_r_valid),
      .q_rise(q_rise), .hit_cnt(hit_cnt)
   );

   or_gate #(.EXT_W(1), .PIPE_STAGES(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .x_ext(x_ext_s),
      .in_valid(in_valid), .q(q_s), .q_r(q_r_s), .q_r_valid(q_r_valid_s),
      .q_rise(q_rise_s), .hit_cnt(hit_cnt_s)
   );

   // Clock only toggles once enabled so the truth table runs clockless.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; x1 = 1'b0; x2 = 1'b0; x3 = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; x1 = 1'b0; x2 = 1'b0; x3 = 1'b0; x_ext = '0; x_ext_s = 1'b0; in_valid = 1'b0;

      // Truth table with no clock running and rst asserted.
      for (int i = 0; i < 8; i++) begin
         code = 3'(i);
         {x1, x2, x3} = code;
         #10;
         check($sformatf("truth_%0d", i), {31'b0, q}, (i == 0) ? 32'd0 : 32'd1);
      end
      {x1, x2, x3} = 3'b000;
      x_ext = 4'b1000;
      #10;
      check("ext_msb", {31'b0, q}, 32'd1);
      x_ext = '0;
      #10;
      check("ext_zero", {31'b0, q}, 32'd0);

      clk_en = 1'b1;
      tick();
      tick();
      check("rst_q_r", {31'b0, q_r}, 32'd0);
      check("rst_q_r_valid", {31'b0, q_r_valid}, 32'd0);
      check("rst_q_rise", {31'b0, q_rise}, 32'd0);
      check("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
      rst = 1'b0;

      // Latency: single valid pulse on x2.
      x2 = 1'b1; in_valid = 1'b1;
      tick();
      x2 = 1'b0; in_valid = 1'b0;
      check("lat_c1_q_r", {31'b0, q_r}, 32'd0);
      check("lat_c1_valid", {31'b0, q_r_valid}, 32'd0);
      tick();
      check("lat_c2_q_r", {31'b0, q_r}, 32'd1);
      check("lat_c2_valid", {31'b0, q_r_valid}, 32'd1);
      tick();
      check("lat_c3_q_r", {31'b0, q_r}, 32'd0);
      check("lat_c3_valid", {31'b0, q_r_valid}, 32'd0);
      check("lat_c3_rise", {31'b0, q_rise}, 32'd1);
      check("lat_c3_cnt", {16'b0, hit_cnt}, 32'd1);

      // Edge/count over valid sequence 0,1,1,0,1.
      do_reset();
      rise_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 5);
         x1 = (i < 5) ? seq[i][0] : 1'b0;
         tick();
         if (q_rise === 1'b1) rise_cnt++;
      end
      check("edge_rise_pulses", rise_cnt, 32'd2);
      check("edge_hit_cnt", {16'b0, hit_cnt}, 32'd3);
      check("edge_sat_cnt", {30'b0, hit_cnt_s}, 32'd3);

      // Saturation: five hits into a 2-bit counter.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         x1 = 1'b1; in_valid = 1'b1;
         tick();
      end
      x1 = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("sat_cnt", {30'b0, hit_cnt_s}, 32'd3);
      check("sat_wide_cnt", {16'b0, hit_cnt}, 32'd5);
      x1 = 1'b1; in_valid = 1'b1;
      tick();
      tick();
      x1 = 1'b0; in_valid = 1'b0;
      tick();
      tick();
      check("sat_held", {30'b0, hit_cnt_s}, 32'd3);
      check("sat_wide_cnt2", {16'b0, hit_cnt}, 32'd7);

      // Reset mid-stream with in-flight valid samples.
      do_reset();
      x3 = 1'b1; in_valid = 1'b1;
      tick();
      tick();
      tick();
      check("mid_pre_valid", {31'b0, q_r_valid}, 32'd1);
      check("mid_pre_cnt", {16'b0, hit_cnt}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_q_during_rst", {31'b0, q}, 32'd1);
      tick();
      check("mid_q_r", {31'b0, q_r}, 32'd0);
      check("mid_q_r_valid", {31'b0, q_r_valid}, 32'd0);
      check("mid_q_rise", {31'b0, q_rise}, 32'd0);
      check("mid_hit_cnt", {16'b0, hit_cnt}, 32'd0);
      check("mid_sat_cnt", {30'b0, hit_cnt_s}, 32'd0);
      x3 = 1'b0;
      #1;
      check("mid_q_tracks", {31'b0, q}, 32'd0);
      x1 = 1'b1; in_valid = 1'b1;
      tick();
      check("rst_priority", {31'b0, q_r_valid}, 32'd0);
      rst = 1'b0;
      tick();
      x1 = 1'b0; in_valid = 1'b0;
      check("post_rst_c1", {31'b0, q_r_valid}, 32'd0);
      tick();
      check("post_rst_c2_valid", {31'b0, q_r_valid}, 32'd1);
      check("post_rst_c2_q_r", {31'b0, q_r}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
